// File: rtl/reduce_tree_pkg.sv
// Shared types and constants for the reduce_tree pipelined reduction block.
package reduce_tree_pkg;

    // Per-beat reduction operator; travels down the pipeline with its beat.
    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_AND = 2'd1,
        MODE_OR  = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    // Width of the optional accepted-output counter.
    localparam int COUNT_W = 16;

endpackage

// File: rtl/reduce_tree_if.sv
// Valid/ready bus for reduce_tree: input beat channel plus result channel.
// Optional REDUCE_TREE_COUNT_EN adds the out_count result-side signal.
interface reduce_tree_if #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8
);
    import reduce_tree_pkg::*;

    localparam int LEVELS = $clog2(NUM_CH);
    localparam int OUT_W  = WIDTH + LEVELS;

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    mode_e                   in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
`ifdef REDUCE_TREE_COUNT_EN
    logic [COUNT_W-1:0]      out_count;
`endif

`ifdef REDUCE_TREE_COUNT_EN
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`else
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/reduce_tree_node.sv
// Registered two-input reduction node; output is one bit wider than its
// operands so an ADD can never overflow.
module reduce_node
    import reduce_tree_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  mode_e           mode,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    output logic [IN_W:0]   y
);

    logic [IN_W:0] a_ext;
    logic [IN_W:0] b_ext;
    logic [IN_W:0] res;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Combine the zero-extended operands according to the beat's operator.
    always_comb begin
        // NOTE: default assignment first so no path leaves res unassigned (no latch).
        res = '0;
        case (mode)
            MODE_ADD: res = a_ext + b_ext;
            MODE_AND: res = a_ext & b_ext;
            MODE_OR:  res = a_ext | b_ext;
            MODE_XOR: res = a_ext ^ b_ext;
        endcase
    end

    // Node register: loads on the pipeline advance enable.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too, so out_data reads 0 straight after reset.
        if (rst) begin
            y <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignment for all clocked state.
            y <= res;
        end
    end

endmodule

// File: rtl/reduce_tree.sv
// Pipelined NUM_CH-to-1 reduction tree with valid/ready handshake.
// One binary tree level per pipeline stage; latency LEVELS = $clog2(NUM_CH).
// Optional feature: define REDUCE_TREE_COUNT_EN to add the 16-bit out_count
// accepted-output counter.
module reduce_tree
    import reduce_tree_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8
) (
    input logic          clk,
    input logic          rst,
    reduce_tree_if.slave bus
);

    localparam int LEVELS = $clog2(NUM_CH);
    localparam int OUT_W  = WIDTH + LEVELS;

    logic             en;
    logic [LEVELS:1]  vld_q;
    mode_e            mode_q [1:LEVELS];
    // Level 0 holds the input lanes; level k holds the NUM_CH>>k node outputs,
    // zero-extended to OUT_W. Slots beyond a level's node count are tied to 0.
    logic [OUT_W-1:0] node_q [0:LEVELS][0:NUM_CH-1];

    // The whole pipeline advances together unless a result is stuck at the output.
    assign en           = !vld_q[LEVELS] || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        assign node_q[0][n] = OUT_W'(bus.in_data[n*WIDTH +: WIDTH]);
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int IN_W  = WIDTH + l - 1;
        localparam int NODES = NUM_CH >> l;

        mode_e lvl_mode;
        logic  lvl_en;

        // First level only captures data on an accepted beat; deeper levels
        // use the mode that travelled with the beat in the previous stage.
        if (l == 1) begin : g_first
            assign lvl_mode = bus.in_mode;
            assign lvl_en   = en && bus.in_valid;
        end else begin : g_rest
            assign lvl_mode = mode_q[l-1];
            assign lvl_en   = en;
        end

        for (genvar n = 0; n < NUM_CH; n++) begin : g_node
            if (n < NODES) begin : g_inst
                logic [IN_W:0] y;

                reduce_node #(
                    .IN_W (IN_W)
                ) u_node (
                    .clk  (clk),
                    .rst  (rst),
                    .en   (lvl_en),
                    .mode (lvl_mode),
                    .a    (node_q[l-1][2*n][IN_W-1:0]),
                    .b    (node_q[l-1][2*n+1][IN_W-1:0]),
                    .y    (y)
                );

                assign node_q[l][n] = OUT_W'(y);
            end else begin : g_pad
                assign node_q[l][n] = '0;
            end
        end
    end

    // Stage valid bits and per-stage modes shift along with the node registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 1; k <= LEVELS; k++) begin
                mode_q[k] <= MODE_ADD;
            end
        end else if (en) begin
            vld_q[1] <= bus.in_valid;
            if (bus.in_valid) begin
                mode_q[1] <= bus.in_mode;
            end
            for (int k = 2; k <= LEVELS; k++) begin
                vld_q[k]  <= vld_q[k-1];
                mode_q[k] <= mode_q[k-1];
            end
        end
    end

    assign bus.out_valid = vld_q[LEVELS];
    assign bus.out_data  = node_q[LEVELS][0];

`ifdef REDUCE_TREE_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    // Count completed output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_reduce_tree.sv
// Self-checking bench for reduce_tree (NUM_CH=4, WIDTH=8). Expected results
// come from a lane-loop reference model and are queued on acceptance; a
// negedge monitor pops and compares on every output handshake.
module tb_reduce_tree;
    import reduce_tree_pkg::*;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int OUT_W  = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reduce_tree_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    reduce_tree #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int last_acc = 0;
    bit stop     = 1'b0;

    logic [OUT_W-1:0] exp_q   [$];
    logic [OUT_W-1:0] out_log [$];
    int               out_cyc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: fold all lanes with the chosen operator using plain integers.
    function automatic logic [OUT_W-1:0] model(input logic [NUM_CH*WIDTH-1:0] lanes, input mode_e m);
        int unsigned acc;
        int unsigned lane;
        acc = (m == MODE_AND) ? 32'hFF : 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane = 32'(lanes[i*WIDTH +: WIDTH]);
            case (m)
                MODE_ADD: acc = acc + lane;
                MODE_AND: acc = acc & lane;
                MODE_OR:  acc = acc | lane;
                MODE_XOR: acc = acc ^ lane;
            endcase
        end
        return OUT_W'(acc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshake rule plus scoreboard comparison on every output transfer.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                else check("out_data", bus.out_data, exp_q.pop_front());
                out_log.push_back(bus.out_data);
                out_cyc.push_back(cyc);
                n_out++;
            end
        end
    end

    // Present a beat until accepted; push its expected result on acceptance.
    task automatic send(input logic [NUM_CH*WIDTH-1:0] d, input mode_e m);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(d, m));
                last_acc = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Single beat with out_ready=1: invisible after the first edge, valid after the second.
    task automatic lat_test(input logic [31:0] d, input mode_e m, input logic [OUT_W-1:0] expv, input string name);
        send(d, m);
        @(negedge clk);
        check({name, "_valid_early"}, bus.out_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_data"}, bus.out_data, expv);
        @(posedge clk);
        #1;
        if (out_cyc.size() == 0) check({name, "_no_output"}, 0, 1);
        else check({name, "_latency"}, out_cyc[out_cyc.size()-1] - last_acc, 2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = MODE_ADD;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency and boundary operands.
        lat_test(32'hFFFF_FFFF, MODE_ADD, 10'h3FC, "add_ff");
        lat_test(32'hFFFF_FFFF, MODE_AND, 10'h0FF, "and_ff");
        lat_test(32'hFFFF_FFFF, MODE_XOR, 10'h000, "xor_ff");

        // Back-to-back XOR, OR, AND on one-hot lanes.
        n0 = out_log.size();
        send(32'h0804_0201, MODE_XOR);
        send(32'h0804_0201, MODE_OR);
        send(32'h0804_0201, MODE_AND);
        drain();
        check("b2b_count", out_log.size() - n0, 3);
        if (out_log.size() >= n0 + 3) begin
            check("b2b_xor", out_log[n0], 10'h00F);
            check("b2b_or", out_log[n0+1], 10'h00F);
            check("b2b_and", out_log[n0+2], 10'h000);
            check("b2b_gap1", out_cyc[n0+1] - out_cyc[n0], 1);
            check("b2b_gap2", out_cyc[n0+2] - out_cyc[n0+1], 1);
        end

        // Backpressure: stall once A reaches the output, then release.
        n0   = out_log.size();
        seen = 1'b0;
        fork
            begin
                send(32'h4030_2010, MODE_ADD);
                send(32'hF00F_00FF, MODE_OR);
                send(32'h1109_0503, MODE_AND);
            end
            begin
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) seen = 1'b1;
                end
                bus.out_ready = 1'b0;
                check("bp_seen", seen, 1);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_hold_valid", bus.out_valid, 1);
                    check("bp_hold_data", bus.out_data, 10'h0A0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", out_log.size() - n0, 3);
        if (out_log.size() >= n0 + 3) begin
            check("bp_a", out_log[n0], 10'h0A0);
            check("bp_b", out_log[n0+1], 10'h0FF);
            check("bp_c", out_log[n0+2], 10'h001);
        end

        // Bubble: valid, idle, valid -> one invalid cycle between outputs.
        n0 = out_log.size();
        send(32'h0101_0101, MODE_ADD);
        @(posedge clk);
        #1;
        send(32'h0202_0202, MODE_ADD);
        drain();
        check("bubble_count", out_log.size() - n0, 2);
        if (out_log.size() >= n0 + 2) begin
            check("bubble_gap", out_cyc[n0+1] - out_cyc[n0], 2);
            check("bubble_v1", out_log[n0], 10'h004);
            check("bubble_v2", out_log[n0+1], 10'h008);
        end

        // Asynchronous reset with two beats in flight.
        send(32'h1111_1111, MODE_ADD);
        send(32'h2222_2222, MODE_ADD);
        check("rst_pre_valid", bus.out_valid, 1);
        n0  = out_log.size();
        rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_data", bus.out_data, 0);
        check("rst_async_ready", bus.in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_test(32'h00FF_55AA, MODE_ADD, 10'h1FE, "post_rst");
        drain();
        check("post_rst_count", out_log.size() - n0, 1);

        // Randomized traffic with random backpressure.
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        send(32'($urandom), mode_e'($urandom_range(3)));
                    end
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(2) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

`ifdef REDUCE_TREE_COUNT_EN
        // Counter: reset value, 65537 handshakes wrap to 1, stall leaves it unchanged.
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("cnt_reset", bus.out_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n0  = n_out;
        begin
            int acc = 0;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'h0101_0101;
            bus.in_mode   = MODE_ADD;
            for (int i = 0; i < 70000 && acc < 65537; i++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    exp_q.push_back(model(32'h0101_0101, MODE_ADD));
                    acc++;
                end
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b0;
            check("cnt_accepted", acc, 65537);
        end
        drain();
        check("cnt_outputs", n_out - n0, 65537);
        check("cnt_wrap", bus.out_count, 16'h0001);
        bus.out_ready = 1'b0;
        send(32'h0303_0303, MODE_OR);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("cnt_stall_valid", bus.out_valid, 1);
        check("cnt_stall_hold", bus.out_count, 16'h0001);
        bus.out_ready = 1'b1;
        drain();
        check("cnt_after_release", bus.out_count, 16'h0002);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
